// File: rtl/result_fifo_if.sv
// Write/pop handshake bundle between the merged measure-lane write port,
// the register-read logic and the result FIFO.
interface result_fifo_if;
    logic        wr_en_i;
    logic [63:0] wr_data_i;
    logic        rd_en_i;
    logic [63:0] rd_data_o;
    logic        rd_valid_o;

    // Producer/consumer side: drives the write strobe and pop request.
    modport master (
        output wr_en_i,
        output wr_data_i,
        output rd_en_i,
        input  rd_data_o,
        input  rd_valid_o
    );

    // FIFO side.
    modport slave (
        input  wr_en_i,
        input  wr_data_i,
        input  rd_en_i,
        output rd_data_o,
        output rd_valid_o
    );
endinterface

// File: rtl/result_fifo.sv
// Measurement-result buffer: captures 64-bit gate results on a one-cycle
// strobe, hands out the oldest entry on pop, and reports level, overflow
// count and a level-threshold interrupt. All outputs come straight from flops.
module result_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic [AW:0]   thresh_i,
    result_fifo_if.slave  bus,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o,
    output logic [15:0]   ovf_cnt_o,
    output logic          irq_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [63:0] mem_q [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   ovf_q, ovf_d;
    logic [63:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          irq_q, irq_d;

    logic is_empty, is_full, pop_acc, wr_acc, wr_drop;

    // Accept decisions come from the registered count; a pop frees the slot
    // a same-cycle write needs when full, but an empty FIFO never bypasses.
    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == FULL_LVL);
        pop_acc  = bus.rd_en_i && !is_empty;
        wr_acc   = bus.wr_en_i && (!is_full || pop_acc);
        wr_drop  = bus.wr_en_i && !wr_acc;
    end

    // Next-state for pointers, count, overflow counter and read port; flush wins.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (clr_i) begin
            wp_d      = '0;
            rp_d      = '0;
            count_d   = '0;
            ovf_d     = '0;
            rd_data_d = '0;
        end else begin
            if (wr_acc) begin
                wp_d = wp_q + AW'(1);
            end
            if (pop_acc) begin
                rp_d       = rp_q + AW'(1);
                rd_data_d  = mem_q[rp_q];
                rd_valid_d = 1'b1;
            end
            if (wr_acc && !pop_acc) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop_acc && !wr_acc) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (wr_drop && (ovf_q != 16'hFFFF)) begin
                ovf_d = ovf_q + 16'd1;
            end
        end
    end

    // Status flags are derived from the post-update count so they line up
    // with level_o in the same cycle.
    always_comb begin
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_LVL);
        irq_d   = (thresh_i != '0) && (count_d >= thresh_i);
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            irq_q      <= irq_d;
        end
    end

    // Storage array; no reset needed since pointers/count gate every read.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !clr_i) begin
            mem_q[wp_q] <= bus.wr_data_i;
        end
    end

    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign level_o        = count_q;
    assign ovf_cnt_o      = ovf_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo (DEPTH=16): a vector table for the basic
// write/pop/threshold flow plus hand sequences for fill/overflow/flush/reset.
module tb_result_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_sys;
    logic          rst_n;
    logic          clr;
    logic [AW:0]   thresh;
    logic          empty, full, irq;
    logic [AW:0]   level;
    logic [15:0]   ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    result_fifo_if bus ();

    result_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i     (clk_sys),
        .rst_n_i   (rst_n),
        .clr_i     (clr),
        .thresh_i  (thresh),
        .bus       (bus),
        .empty_o   (empty),
        .full_o    (full),
        .level_o   (level),
        .ovf_cnt_o (ovf_cnt),
        .irq_o     (irq)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        clr;
        logic        wr;
        logic [63:0] wd;
        logic        rd;
        logic [4:0]  th;
        logic [4:0]  lvl;
        logic        emp;
        logic        ful;
        logic [15:0] ovf;
        logic        irq;
        logic        rv;
        logic [63:0] rdata;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the expected status; counts as one vector.
    task automatic chk_all(input string name, input logic [4:0] lvl, input logic emp,
                           input logic ful, input logic [15:0] ovf, input logic ir,
                           input logic rv, input logic [63:0] rdata);
        n_vec++;
        chk({name, ".level"},   64'(level),          64'(lvl));
        chk({name, ".empty"},   64'(empty),          64'(emp));
        chk({name, ".full"},    64'(full),           64'(ful));
        chk({name, ".ovf"},     64'(ovf_cnt),        64'(ovf));
        chk({name, ".irq"},     64'(irq),            64'(ir));
        chk({name, ".rvalid"},  64'(bus.rd_valid_o), 64'(rv));
        chk({name, ".rdata"},   bus.rd_data_o,       rdata);
    endtask

    // Drive one cycle of inputs at the falling edge, return 1 ns after the next rising edge.
    task automatic step(input logic c, input logic w, input logic [63:0] wd,
                        input logic r, input logic [4:0] th);
        @(negedge clk_sys);
        clr           = c;
        bus.wr_en_i   = w;
        bus.wr_data_i = wd;
        bus.rd_en_i   = r;
        thresh        = th;
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [63:0] word(input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    localparam logic [63:0] W1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] W2 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] W3 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] NEW = 64'hF00D_F00D_F00D_F00D;

    task automatic fill_five_with_ovf();
        for (int k = 1; k <= 17; k++) step(0, 1, word(k), 0, 0);
        for (int k = 1; k <= 11; k++) step(0, 0, 64'd0, 1, 0);
        chk_all("prefill", 5'd5, 0, 0, 16'd1, 0, 1, word(11));
    endtask

    initial begin
        //      clr wr  wd               rd th | lvl emp ful ovf irq rv rdata
        vt[0]  = '{0, 1, W1,              0, 0,  1, 0, 0, 0, 0, 0, 64'd0};
        vt[1]  = '{0, 1, W2,              0, 0,  2, 0, 0, 0, 0, 0, 64'd0};
        vt[2]  = '{0, 0, 64'd0,           1, 0,  1, 0, 0, 0, 0, 1, W1};
        vt[3]  = '{0, 0, 64'd0,           1, 0,  0, 1, 0, 0, 0, 1, W2};
        vt[4]  = '{0, 0, 64'd0,           1, 0,  0, 1, 0, 0, 0, 0, W2};
        vt[5]  = '{0, 1, W3,              1, 0,  1, 0, 0, 0, 0, 0, W2};
        vt[6]  = '{0, 0, 64'd0,           1, 0,  0, 1, 0, 0, 0, 1, W3};
        vt[7]  = '{0, 1, 64'hD1,          0, 4,  1, 0, 0, 0, 0, 0, W3};
        vt[8]  = '{0, 1, 64'hD2,          0, 4,  2, 0, 0, 0, 0, 0, W3};
        vt[9]  = '{0, 1, 64'hD3,          0, 4,  3, 0, 0, 0, 0, 0, W3};
        vt[10] = '{0, 1, 64'hD4,          0, 4,  4, 0, 0, 0, 1, 0, W3};
        vt[11] = '{0, 0, 64'd0,           1, 4,  3, 0, 0, 0, 0, 1, 64'hD1};
        vt[12] = '{0, 1, 64'hD5,          0, 4,  4, 0, 0, 0, 1, 0, 64'hD1};
        vt[13] = '{0, 0, 64'd0,           0, 0,  4, 0, 0, 0, 0, 0, 64'hD1};
        vt[14] = '{1, 1, 64'hEE,          1, 4,  0, 1, 0, 0, 0, 0, 64'd0};

        rst_n = 1'b0;
        clr = 1'b0;
        thresh = '0;
        bus.wr_en_i = 1'b0;
        bus.wr_data_i = '0;
        bus.rd_en_i = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk_all("reset", 5'd0, 1, 0, 16'd0, 0, 0, 64'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vt[i].clr, vt[i].wr, vt[i].wd, vt[i].rd, vt[i].th);
            chk_all($sformatf("vec%0d", i), vt[i].lvl, vt[i].emp, vt[i].ful,
                    vt[i].ovf, vt[i].irq, vt[i].rv, vt[i].rdata);
        end

        // Fill to 16, then two dropped writes.
        for (int k = 1; k <= 18; k++) begin
            step(0, 1, word(k), 0, 0);
            if (k == 15) chk_all("fill15", 5'd15, 0, 0, 16'd0, 0, 0, 64'd0);
            if (k == 16) chk_all("fill16", 5'd16, 0, 1, 16'd0, 0, 0, 64'd0);
            if (k == 18) chk_all("fill18", 5'd16, 0, 1, 16'd2, 0, 0, 64'd0);
        end

        // Full with simultaneous write and pop: no drop, oldest word out.
        step(0, 1, NEW, 1, 0);
        chk_all("full_wr_rd", 5'd16, 0, 1, 16'd2, 0, 1, word(1));

        // Drain: words 2..16, then the word written while full.
        for (int k = 2; k <= 17; k++) begin
            step(0, 0, 64'd0, 1, 0);
            chk_all($sformatf("drain%0d", k), 5'(17 - k), k == 17, 0, 16'd2, 0, 1,
                    (k == 17) ? NEW : word(k));
        end

        // Pop while empty: no pulse, data held.
        step(0, 0, 64'd0, 1, 0);
        chk_all("pop_empty", 5'd0, 1, 0, 16'd2, 0, 0, NEW);
        step(0, 0, 64'd0, 0, 0);
        chk_all("idle", 5'd0, 1, 0, 16'd2, 0, 0, NEW);

        // Flush with write and pop in the same cycle.
        step(1, 0, 64'd0, 0, 0);
        fill_five_with_ovf();
        step(1, 1, 64'h99, 1, 0);
        chk_all("clr_prio", 5'd0, 1, 0, 16'd0, 0, 0, 64'd0);
        step(0, 1, 64'h77, 0, 0);
        step(0, 0, 64'd0, 1, 0);
        chk_all("after_clr", 5'd0, 1, 0, 16'd0, 0, 1, 64'h77);

        // Same fill, then an asynchronous reset pulse mid-cycle.
        fill_five_with_ovf();
        step(0, 0, 64'd0, 0, 5'd2);
        chk_all("pre_rst", 5'd5, 0, 0, 16'd1, 1, 0, word(11));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 5'd0, 1, 0, 16'd0, 0, 0, 64'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
        step(0, 0, 64'd0, 1, 0);
        chk_all("post_rst", 5'd0, 1, 0, 16'd0, 0, 0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_fifo.md
# result_fifo

Measurement-result buffer sitting directly downstream of the five `measure` lanes' merged write port in the frequency-meter AXI block. It captures each 64-bit result on the one-cycle write strobe, so back-to-back gate results are never lost between CPU reads. It presents the oldest entry to the register-read logic on a pop request. It also reports fill level, an overflow count and a threshold interrupt.

## Interface

- `DEPTH`, 16, number of 64-bit entries; power of two, 2..256
- `AW`, `$clog2(DEPTH)`, pointer width; level fields are `AW+1` bits
- `clk_i`  in  1  system clock (AXI clock domain)
- `rst_n_i`  in  1  asynchronous active-low reset
- `clr_i`  in  1  synchronous flush strobe
- `wr_en_i`  in  1  result write strobe (merged lane write enable)
- `wr_data_i`  in  64  result word
- `rd_en_i`  in  1  pop request
- `thresh_i`  in  AW+1  interrupt threshold; 0 disables the interrupt
- `rd_data_o`  out  64  last popped word
- `rd_valid_o`  out  1  one-cycle pulse: `rd_data_o` updated
- `empty_o`  out  1  FIFO holds 0 entries
- `full_o`  out  1  FIFO holds DEPTH entries
- `level_o`  out  AW+1  current entry count, 0..DEPTH
- `ovf_cnt_o`  out  16  dropped-write count, saturating
- `irq_o`  out  1  level at or above threshold

## Operation

- Storage: DEPTH×64 register array, write pointer `wp` and read pointer `rp` (AW bits, natural wrap at DEPTH), plus `count` (AW+1 bits).
- Write accept: `wr_en_i && (!full || pop_accept)`. An accepted write stores `wr_data_i` at `wp` and increments `wp`.
- Pop accept: `rd_en_i && !empty`. An accepted pop loads `mem[rp]` into `rd_data_o`, pulses `rd_valid_o` next cycle and increments `rp`.
- Pop request when empty: ignored. `rd_data_o` holds its value and no pulse is generated.
- Count update:
  - +1 on write only
  - −1 on pop only
  - unchanged on both, or on neither
- Full plus simultaneous write and pop: both are accepted, there is no drop, and the count stays DEPTH.
- Empty plus simultaneous write and pop: the write is accepted and the pop is ignored (no bypass). The count becomes 1.
- Write when full with no pop: the write is dropped and the contents are unchanged. `ovf_cnt` increments and saturates at 0xFFFF.
- `clr_i` has priority over write and pop in the same cycle:
  - `wp`, `rp`, `count` and `ovf_cnt` are zeroed
  - `rd_data_o` is zeroed and `rd_valid_o` is 0
  - array contents are not cleared
- `irq_o = (thresh_i != 0) && (count >= thresh_i)`. It is registered from the post-update count.
- `empty_o`, `full_o` and `level_o` are registered, consistent with `count`.

## Timing

- Reset (async assert, sync release by the system):
  - `rd_data_o` = 0, `rd_valid_o` = 0
  - `empty_o` = 1, `full_o` = 0
  - `level_o` = 0, `ovf_cnt_o` = 0, `irq_o` = 0
  - all pointers are 0
- Reset asserted mid-operation discards all contents immediately. No pulse is emitted.
- Write latency: `wr_en_i` sampled at edge N → `level_o`/`empty_o`/`full_o`/`irq_o` reflect it after edge N. The entry is poppable from cycle N+1.
- Pop latency: `rd_en_i` sampled at edge N → `rd_data_o` valid and `rd_valid_o` high for exactly the cycle after edge N.
- Back-to-back pops: one entry per cycle while non-empty.
- Back-to-back writes: one per cycle, matching the one-cycle `wr_en_i` strobe.
- `thresh_i` is sampled every cycle. A change takes effect on `irq_o` one cycle later.
- No combinational path from any input to any output.

## Test plan

- Reset, then write 0x1111_2222_3333_4444 and 0xAAAA_BBBB_CCCC_DDDD, then pop twice:
  - `level_o` reads 1, 2, 1, 0
  - `rd_data_o` returns both words in order, each with a single `rd_valid_o` pulse one cycle after `rd_en_i`
- DEPTH=16, write 18 distinct words with no pops:
  - `full_o` is set after write 16 and `ovf_cnt_o` = 2
  - 16 pops return words 1..16, then `empty_o` = 1
  - a 17th pop gives no `rd_valid_o` and `rd_data_o` is unchanged
- With the FIFO full, assert write and pop together:
  - `level_o` stays 16 and `ovf_cnt_o` stays unchanged
  - the popped word is the oldest
  - the new word appears last in the drain order
- With the FIFO empty, assert write and pop together:
  - no `rd_valid_o`, and `level_o` = 1
  - the next pop returns the written word
- `thresh_i` = 4:
  - `irq_o` rises the cycle after the 4th write and falls the cycle after the pop that leaves 3
  - setting `thresh_i` = 0 forces `irq_o` = 0 one cycle later
- Fill 5 entries with `ovf_cnt_o` > 0, then pulse `clr_i` together with `wr_en_i` and `rd_en_i`:
  - next cycle: `level_o` = 0, `empty_o` = 1, `ovf_cnt_o` = 0, `rd_data_o` = 0, no `rd_valid_o`
  - repeat with `rst_n_i` low for 1 cycle instead: all outputs are at reset values immediately
